// File: rtl/spatz_simd_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : spatz_simd_result_collector
// Brief    : Collects per-lane SIMD results for one writeback descriptor,
//            assembles the vector word and queues it in a small FWFT FIFO
//            toward the VRF write port.
// Options  : SPATZ_COLLECTOR_STALL_CNT_EN adds a saturating 16-bit counter
//            of output stall cycles on port stall_cnt_o.
// Revision : 1.0 - initial release
// ============================================================================
module spatz_simd_result_collector #(
    parameter int unsigned NrLanes   = 4,
    parameter int unsigned LaneWidth = 16,
    parameter int unsigned Depth     = 2,
    parameter int unsigned AddrWidth = 5,
    parameter int unsigned IdWidth   = 3
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             issue_valid_i,
    output logic                             issue_ready_o,
    input  logic [AddrWidth-1:0]             issue_addr_i,
    input  logic [NrLanes*LaneWidth/8-1:0]   issue_be_i,
    input  logic [IdWidth-1:0]               issue_id_i,
    input  logic [NrLanes-1:0]               issue_lane_en_i,
    input  logic [NrLanes*LaneWidth-1:0]     lane_result_i,
    input  logic [NrLanes-1:0]               lane_valid_i,
    output logic [NrLanes-1:0]               lane_ready_o,
    output logic                             wb_valid_o,
    input  logic                             wb_ready_i,
    output logic [AddrWidth-1:0]             wb_addr_o,
    output logic [NrLanes*LaneWidth-1:0]     wb_data_o,
    output logic [NrLanes*LaneWidth/8-1:0]   wb_be_o,
    output logic [IdWidth-1:0]               wb_id_o,
    output logic                             busy_o
`ifdef SPATZ_COLLECTOR_STALL_CNT_EN
    ,
    output logic [15:0]                      stall_cnt_o
`endif
);

    localparam int unsigned DATA_W   = NrLanes * LaneWidth;
    localparam int unsigned BE_W     = DATA_W / 8;
    localparam int unsigned LANE_B   = LaneWidth / 8;
    localparam int unsigned ENTRY_W  = AddrWidth + DATA_W + BE_W + IdWidth;
    localparam int unsigned PTR_W    = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CNT_W    = $clog2(Depth + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(Depth - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(Depth);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PUSH    = 2'd2
    } state_e;

    // Descriptor / collection state
    state_e                 state_q, state_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic [BE_W-1:0]        be_q, be_d;
    logic [IdWidth-1:0]     id_q, id_d;
    logic [NrLanes-1:0]     lane_en_q, lane_en_d;
    logic [NrLanes-1:0]     captured_q, captured_d;
    logic [DATA_W-1:0]      data_q, data_d;

    // Output FIFO state
    logic [ENTRY_W-1:0]     fifo_q [Depth];
    logic [ENTRY_W-1:0]     fifo_d [Depth];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_issue_ready;
    logic [NrLanes-1:0]     w_lane_ready;
    logic [NrLanes-1:0]     w_cap_now;
    logic [DATA_W-1:0]      w_data_mask;
    logic [BE_W-1:0]        w_be_mask;
    logic [ENTRY_W-1:0]     w_entry;

    // Disabled lanes contribute neither data nor byte enables to the word.
    for (genvar k = 0; k < NrLanes; k++) begin : g_lane_mask
        assign w_data_mask[k*LaneWidth +: LaneWidth] = {LaneWidth{lane_en_q[k]}};
        assign w_be_mask[k*LANE_B +: LANE_B]         = {LANE_B{lane_en_q[k]}};
    end

    assign w_full  = (count_q == CNT_FULL);
    assign w_empty = (count_q == '0);
    assign w_pop   = ~w_empty & wb_ready_i;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign w_push  = (state_q == ST_PUSH) & (~w_full | w_pop);
    assign w_entry = {addr_q, data_q & w_data_mask, be_q & w_be_mask, id_q};

    // Collector FSM: descriptor latch, per-lane capture and push hand-off
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        be_d          = be_q;
        id_d          = id_q;
        lane_en_d     = lane_en_q;
        captured_d    = captured_q;
        data_d        = data_q;
        w_issue_ready = 1'b0;
        w_lane_ready  = '0;
        w_cap_now     = '0;
        case (state_q)
            ST_IDLE: begin
                w_issue_ready = 1'b1;
                if (issue_valid_i) begin
                    addr_d     = issue_addr_i;
                    be_d       = issue_be_i;
                    id_d       = issue_id_i;
                    lane_en_d  = issue_lane_en_i;
                    captured_d = '0;
                    state_d    = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                w_lane_ready = lane_en_q & ~captured_q;
                w_cap_now    = lane_valid_i & w_lane_ready;
                captured_d   = captured_q | w_cap_now;
                for (int k = 0; k < NrLanes; k++) begin
                    if (w_cap_now[k]) begin
                        data_d[k*LaneWidth +: LaneWidth] = lane_result_i[k*LaneWidth +: LaneWidth];
                    end
                end
                if ((captured_d & lane_en_q) == lane_en_q) begin
                    state_d = ST_PUSH;
                end
            end
            ST_PUSH: begin
                if (w_push) begin
                    w_issue_ready = 1'b1;
                    if (issue_valid_i) begin
                        addr_d     = issue_addr_i;
                        be_d       = issue_be_i;
                        id_d       = issue_id_i;
                        lane_en_d  = issue_lane_en_i;
                        captured_d = '0;
                        state_d    = ST_COLLECT;
                    end else begin
                        state_d    = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FIFO pointer, occupancy and storage update
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            fifo_d[wr_ptr_q] = w_entry;
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards descriptor, captures and FIFO contents
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            be_q       <= '0;
            id_q       <= '0;
            lane_en_q  <= '0;
            captured_q <= '0;
            data_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < Depth; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            id_q       <= id_d;
            lane_en_q  <= lane_en_d;
            captured_q <= captured_d;
            data_q     <= data_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            fifo_q     <= fifo_d;
        end
    end

    assign issue_ready_o = w_issue_ready;
    assign lane_ready_o  = w_lane_ready;
    assign wb_valid_o    = ~w_empty;
    assign {wb_addr_o, wb_data_o, wb_be_o, wb_id_o} = fifo_q[rd_ptr_q];
    assign busy_o        = (state_q != ST_IDLE) | ~w_empty;

`ifdef SPATZ_COLLECTOR_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles where the head waits on the VRF
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (~w_empty & ~wb_ready_i & (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Stall counter register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: doc/spatz_simd_result_collector.md
Name: spatz_simd_result_collector

Overview:
- Sits directly downstream of the NrLanes SIMD lanes of the vector functional unit.
- Accepts a writeback descriptor per vector word: destination address, byte enables, tag and active-lane mask.
- Captures each lane's result in whatever cycle that lane becomes valid; fixed-latency ops and the variable-latency serial divider may finish in different cycles.
- Assembles the full word and queues it in a small FIFO toward the VRF write port (valid/ready).

Parameters:
- NrLanes, 4, number of SIMD lanes collected.
- LaneWidth, 16, result bits per lane.
- Depth, 2, output FIFO entries (>=1).
- AddrWidth, 5, VRF word address width.
- IdWidth, 3, instruction tag width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- issue_valid_i  in  1  descriptor valid.
- issue_ready_o  out  1  descriptor accepted when valid&ready.
- issue_addr_i  in  AddrWidth  destination VRF word address.
- issue_be_i  in  NrLanes*LaneWidth/8  byte enables.
- issue_id_i  in  IdWidth  instruction tag.
- issue_lane_en_i  in  NrLanes  lanes expected to deliver a result.
- lane_result_i  in  NrLanes*LaneWidth  lane results; lane k at [k*LaneWidth +: LaneWidth].
- lane_valid_i  in  NrLanes  per-lane result valid.
- lane_ready_o  out  NrLanes  per-lane result consumed.
- wb_valid_o  out  1  FIFO head valid.
- wb_ready_i  in  1  VRF accepts head.
- wb_addr_o  out  AddrWidth  head address.
- wb_data_o  out  NrLanes*LaneWidth  head data.
- wb_be_o  out  NrLanes*LaneWidth/8  head byte enables.
- wb_id_o  out  IdWidth  head tag.
- busy_o  out  1  state != IDLE or FIFO non-empty.

Behaviour:
- Reset values (asynchronous, while rst_i=1):
  - state=IDLE; FIFO empty; capture mask=0; holding data=0.
  - issue_ready_o=1, lane_ready_o=0, wb_valid_o=0, wb_addr/data/be/id=0, busy_o=0.
- Reset mid-operation discards the pending descriptor, all captured lanes and all FIFO entries.
- States:
  - IDLE: issue_ready_o=1. On issue handshake, latch the descriptor, clear the capture mask, go to COLLECT.
  - COLLECT: lane_ready_o[k] = lane_en[k] & ~captured[k].
    - When lane_valid_i[k] & lane_ready_o[k], latch lane k data and set captured[k].
    - When (captured | lanes captured this cycle) covers lane_en, go to PUSH next cycle.
    - lane_en=0 goes to PUSH after one COLLECT cycle.
    - lane_valid_i of disabled or already-captured lanes is ignored (lane_ready_o=0).
  - PUSH: write {addr, data, be, id} into the FIFO when not full, or when full and a pop occurs in the same cycle.
    - Disabled lanes: data forced to 0 and their byte-enable bits forced to 0, regardless of issue_be_i.
    - issue_ready_o=1 only in a PUSH cycle whose push succeeds. A new descriptor accepted then goes straight to COLLECT (back-to-back). Otherwise go to IDLE.
    - If the push is blocked, remain in PUSH with issue_ready_o=0.
- FIFO:
  - Depth entries, first-word-fall-through from registers; wb_* driven from the head entry.
  - Pop on wb_valid_o & wb_ready_i.
  - wb_* are held stable while wb_valid_o=1 and wb_ready_i=0.
  - Pointers wrap modulo Depth.
  - A push into an empty FIFO is visible on wb_valid_o the following cycle.
- Minimum latency: descriptor accepted at cycle 0 → lanes valid in cycle 1 → push in cycle 2 → wb_valid_o=1 in cycle 3.
- Sustained throughput: one word per 2 cycles with back-to-back issue.
- No combinational path from wb_ready_i to lane_ready_o. A path from wb_ready_i to issue_ready_o exists only via a full-FIFO simultaneous pop.

Optional Feature:
- Macro: SPATZ_COLLECTOR_STALL_CNT_EN.
- When defined: adds output port stall_cnt_o (16 bits).
  - Counts cycles with wb_valid_o & ~wb_ready_i.
  - Saturates at 16'hFFFF; reset to 0.
  - Does not affect any other behaviour.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Single word, all lanes valid immediately: issue addr=5, be=8'hFF, id=2, lane_en=4'hF, lanes return 16'h1111..16'h4444 in cycle 1 → cycle 3 wb_valid_o=1, wb_data_o=64'h4444_3333_2222_1111, wb_addr_o=5, wb_id_o=2; pops on wb_ready_i=1.
- Staggered lanes (divider): lanes 0,1 valid in cycle 1, lane 2 in cycle 4, lane 3 in cycle 9 → each lane_ready_o pulses once when its lane is captured; push in cycle 10; data correct; no lane is captured twice.
- Disabled lanes: lane_en=4'b0101, issue_be_i=8'hFF → wb_be_o=8'h33, lanes 1 and 3 data=0; lane_valid_i[1]=1 is ignored.
- Backpressure: Depth=2, wb_ready_i=0, issue 3 descriptors → the third stays in PUSH with issue_ready_o=0. Raise wb_ready_i for one cycle → simultaneous pop and push; wb outputs are stable while stalled; order is preserved.
- Reset mid-operation: assert rst_i in COLLECT with 2 FIFO entries → outputs immediately go to their reset values, busy_o=0; a new descriptor after release completes normally.
- With SPATZ_COLLECTOR_STALL_CNT_EN: hold wb_valid_o=1 with wb_ready_i=0 for 7 cycles → stall_cnt_o=7.
